// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the memory-stage access controller.
// master: the controller. slave: the pipeline and memory responder that surround it.
interface dmem_access_ctrl_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmemerror;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;

  modport master (
    input  start, icode, valE, valA, valP, mem_ack, mem_rdata, mem_err,
    output busy, done, valM, dmemerror, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, icode, valE, valA, valP, mem_ack, mem_rdata, mem_err,
    input  busy, done, valM, dmemerror, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: Y86-64 memory-stage initiator for a req/ack data memory.
// Decodes icode into read/write, picks address/write data, runs one request to the
// responder and reports valM and dmemerror with a one-cycle done pulse.
// Optional feature macro: DMEM_TIMEOUT_EN (abandons a request after TIMEOUT_CYCLES
// cycles without ack and flags an error).
//
// state    | meaning
// S_IDLE   | waiting for start; decode and range-check the operation
// S_ACCESS | mem_req held high, waiting for mem_ack (or timeout)
// S_DONE   | done pulse; valM/dmemerror valid
module dmem_access_ctrl #(
  parameter logic [63:0] ADDR_LIMIT     = 64'd8192,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_is_wr;
  logic        w_is_rd;
  logic        w_is_mem;
  logic        w_addr_ok;
  logic [63:0] w_addr;
  logic [63:0] w_wdata;
  logic        w_ack;
  logic        w_tmo;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic [63:0] r_valM;
  logic        r_dmemerror;

  // Decode icode into direction, address source and write-data source.
  always_comb begin
    w_is_wr = 1'b0;
    w_is_rd = 1'b0;
    w_addr  = 64'd0;
    w_wdata = 64'd0;
    case (bus.icode)
      4'h4, 4'hA: begin
        w_is_wr = 1'b1;
        w_addr  = bus.valE;
        w_wdata = bus.valA;
      end
      4'h8: begin
        w_is_wr = 1'b1;
        w_addr  = bus.valE;
        w_wdata = bus.valP;
      end
      4'h5: begin
        w_is_rd = 1'b1;
        w_addr  = bus.valE;
      end
      4'h9, 4'hB: begin
        w_is_rd = 1'b1;
        w_addr  = bus.valA;
      end
      default: ;
    endcase
  end

  assign w_is_mem  = w_is_wr | w_is_rd;
  assign w_addr_ok = (w_addr < ADDR_LIMIT);
  // An ack only counts while a request is outstanding.
  assign w_ack     = bus.mem_ack & r_mem_req;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt;

  // Down-counter reloaded in IDLE; reaching zero in ACCESS means the request has
  // been high for TIMEOUT_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo_cnt <= TMO_LOAD;
    end else if (r_state == S_ACCESS && r_tmo_cnt != '0) begin
      r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  assign w_tmo = (r_state == S_ACCESS) && (r_tmo_cnt == '0) && !w_ack;
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_is_mem && w_addr_ok) w_state_nxt = S_ACCESS;
          else                       w_state_nxt = S_DONE;
        end
      end
      S_ACCESS: begin
        if (w_ack || w_tmo) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered request, result and error; bus fields keep their last value after
  // completion and are qualified by mem_req only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_valM      <= 64'd0;
      r_dmemerror <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_is_mem && w_addr_ok) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_wr;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_wdata;
              r_dmemerror <= 1'b0;
            end else begin
              r_dmemerror <= w_is_mem;
            end
          end
        end
        S_ACCESS: begin
          if (w_ack) begin
            r_mem_req   <= 1'b0;
            r_dmemerror <= bus.mem_err;
            if (!r_mem_we && !bus.mem_err) r_valM <= bus.mem_rdata;
          end else if (w_tmo) begin
            r_mem_req   <= 1'b0;
            r_dmemerror <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.valM      = r_valM;
  assign bus.dmemerror = r_dmemerror;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
